// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, state and op-select definitions for the ALU control path.
package alu_ctrl_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_OR   = 4'd0;
    localparam alu_op_t OP_AND  = 4'd1;
    localparam alu_op_t OP_NOT  = 4'd2;
    localparam alu_op_t OP_ADD  = 4'd3;
    localparam alu_op_t OP_SUB  = 4'd4;
    localparam alu_op_t OP_NEG  = 4'd5;
    localparam alu_op_t OP_MUL  = 4'd6;
    localparam alu_op_t OP_DIV  = 4'd7;
    localparam alu_op_t OP_SHL  = 4'd8;
    localparam alu_op_t OP_SHR  = 4'd9;
    localparam alu_op_t OP_SHRA = 4'd10;
    localparam alu_op_t OP_ROL  = 4'd11;
    localparam alu_op_t OP_ROR  = 4'd12;
    localparam alu_op_t OP_NOP  = 4'd13;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    function automatic logic op_is_muldiv(input alu_op_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: ALU op select plus class flags for the sequencer.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  alu_op_t opcode,
    output alu_op_t alu_op,
    output logic    is_muldiv,
    output logic    is_nop,
    output logic    is_illegal
);

    always_comb begin
        is_illegal = (opcode > OP_NOP);
        is_nop     = (opcode == OP_NOP);
        is_muldiv  = op_is_muldiv(opcode);
        // Illegal opcodes never reach the datapath; park the select at OR.
        alu_op     = is_illegal ? OP_OR : opcode;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for the ALU: accept, register read, execute, writeback.
// Define ALU_SEQ_FLAGS_EN to add zero/negative result flags captured at writeback.
//
// state   | meaning
// S_IDLE  | ready for a new instruction
// S_READ  | register-file read addresses driven; NOP/illegal retire here
// S_EXEC  | ALU executing; down-counter stretches MUL/DIV
// S_WRITE | writeback strobe and retire
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int REG_AW        = 4,
    parameter int MULDIV_CYCLES = 4,
    localparam int IW           = 4 + 3 * REG_AW
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic [IW-1:0]     instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rf_rd_a,
    output logic [REG_AW-1:0] rf_rd_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic              rf_wr_en,
    output logic              done,
    output logic              illegal
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_n
`endif
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    alu_op_t           alu_op_q;
    logic              muldiv_q;
    logic              nop_q;
    logic              illegal_q;
    logic [REG_AW-1:0] ra_q;
    logic [REG_AW-1:0] rb_q;
    logic [REG_AW-1:0] rc_q;

    alu_op_t dec_op;
    logic    dec_muldiv;
    logic    dec_nop;
    logic    dec_illegal;
    logic    accept;

    alu_op_decode u_decode (
        .opcode     (instr[IW-1 -: 4]),
        .alu_op     (dec_op),
        .is_muldiv  (dec_muldiv),
        .is_nop     (dec_nop),
        .is_illegal (dec_illegal)
    );

    assign instr_ready = (state == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            alu_op_q  <= OP_OR;
            muldiv_q  <= 1'b0;
            nop_q     <= 1'b0;
            illegal_q <= 1'b0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_op_q  <= dec_op;
                        muldiv_q  <= dec_muldiv;
                        nop_q     <= dec_nop;
                        illegal_q <= dec_illegal;
                        ra_q      <= instr[3*REG_AW-1 -: REG_AW];
                        rb_q      <= instr[2*REG_AW-1 -: REG_AW];
                        rc_q      <= instr[REG_AW-1:0];
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    if (nop_q || illegal_q) begin
                        state <= S_IDLE;
                    end else begin
                        cnt   <= muldiv_q ? CNT_W'(MULDIV_CYCLES - 1) : '0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) state <= S_WRITE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state so reset clears them without waiting for a clock.
    assign rf_rd_a    = rb_q;
    assign rf_rd_b    = rc_q;
    assign alu_op     = alu_op_q;
    assign rf_wr_addr = ra_q;
    assign rf_wr_en   = (state == S_WRITE);
    assign done       = (state == S_WRITE) || ((state == S_READ) && (nop_q || illegal_q));
    assign illegal    = (state == S_READ) && illegal_q;

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == S_WRITE) begin
            flag_z <= (alu_result == '0);
            flag_n <= alu_result[DATA_W-1];
        end
    end
`else
    logic unused_alu_result;
    assign unused_alu_result = ^alu_result;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a write scoreboard; flag checks need ALU_SEQ_FLAGS_EN.
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  rf_rd_a;
    logic [3:0]  rf_rd_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_result = 8'h00;
    logic [3:0]  rf_wr_addr;
    logic        rf_wr_en;
    logic        done;
    logic        illegal;
`ifdef ALU_SEQ_FLAGS_EN
    logic        flag_z;
    logic        flag_n;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    alu_op_sequencer dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rf_rd_a     (rf_rd_a),
        .rf_rd_b     (rf_rd_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_en    (rf_wr_en),
        .done        (done),
        .illegal     (illegal)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flag_z      (flag_z),
        .flag_n      (flag_n)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected {addr, op}.
    always @(negedge clock) begin
        if (rf_wr_en === 1'b1) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_wr_addr), 32'(mon_e[7:4]));
                chk("wr_op", 32'(alu_op), 32'(mon_e[3:0]));
            end
            chk("wr_done", 32'(done), 32'd1);
        end
    end

    task automatic send(input logic [15:0] w);
        @(negedge clock);
        chk("ready_before_accept", 32'(instr_ready), 32'd1);
        instr = w;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
    endtask

    task automatic neg();
        @(negedge clock);
    endtask

    initial begin
        logic [15:0] b2b [4];
        int acc [4];
        int idx;

        // reset
        neg();
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rd_a", 32'(rf_rd_a), 32'd0);
        chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        neg();
        clear_n = 1'b1;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);

        // ADD r1 <- r2, r3
        exp_q.push_back({4'd1, 4'd3});
        send(16'h3123);
        neg();
        chk("add_rd_a", 32'(rf_rd_a), 32'd2);
        chk("add_rd_b", 32'(rf_rd_b), 32'd3);
        chk("add_op_t1", 32'(alu_op), 32'd3);
        chk("add_wr_t1", 32'(rf_wr_en), 32'd0);
        chk("add_done_t1", 32'(done), 32'd0);
        chk("add_ready_t1", 32'(instr_ready), 32'd0);
        neg();
        chk("add_op_t2", 32'(alu_op), 32'd3);
        chk("add_wr_t2", 32'(rf_wr_en), 32'd0);
        neg();
        chk("add_op_t3", 32'(alu_op), 32'd3);
        chk("add_wr_t3", 32'(rf_wr_en), 32'd1);
        chk("add_done_t3", 32'(done), 32'd1);
        chk("add_illegal_t3", 32'(illegal), 32'd0);
        neg();
        chk("add_done_t4", 32'(done), 32'd0);
        chk("add_ready_t4", 32'(instr_ready), 32'd1);

        // MUL r4 <- r5, r6 with noise on instr/valid while busy
        exp_q.push_back({4'd4, 4'd6});
        send(16'h6456);
        for (int k = 1; k <= 7; k++) begin
            neg();
            chk($sformatf("mul_ready_k%0d", k), 32'(instr_ready), 32'(k == 7));
            chk($sformatf("mul_wr_k%0d", k), 32'(rf_wr_en), 32'(k == 6));
            if (k < 7) chk($sformatf("mul_rd_a_k%0d", k), 32'(rf_rd_a), 32'd5);
            instr = 16'($urandom);
            instr_valid = (k < 6) ? 1'($urandom) : 1'b0;
        end

        // NOP and illegal opcodes retire after one cycle without writing
        send(16'hD000);
        neg();
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_illegal", 32'(illegal), 32'd0);
        chk("nop_op", 32'(alu_op), 32'd13);
        neg();
        chk("nop_done_after", 32'(done), 32'd0);
        chk("nop_ready_after", 32'(instr_ready), 32'd1);
        send(16'hF123);
        neg();
        chk("opf_done", 32'(done), 32'd1);
        chk("opf_illegal", 32'(illegal), 32'd1);
        chk("opf_wr", 32'(rf_wr_en), 32'd0);
        neg();
        chk("opf_illegal_after", 32'(illegal), 32'd0);
        chk("opf_ready_after", 32'(instr_ready), 32'd1);
        send(16'hE777);
        neg();
        chk("ope_illegal", 32'(illegal), 32'd1);
        chk("ope_done", 32'(done), 32'd1);

        // back-to-back ADDs with valid held high
        b2b[0] = 16'h3112; b2b[1] = 16'h3234; b2b[2] = 16'h3356; b2b[3] = 16'h3478;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            neg();
            if (instr_ready) begin
                if (idx < 4) begin
                    instr = b2b[idx];
                    instr_valid = 1'b1;
                    exp_q.push_back({4'(idx + 1), 4'd3});
                    acc[idx] = cyc;
                    idx++;
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        instr_valid = 1'b0;
        chk("b2b_accepts", 32'(idx), 32'd4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("b2b_gap%0d", i), 32'(acc[i] - acc[i-1]), 32'd4);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        // reset during EXEC of DIV
        send(16'h7abc);
        neg();
        neg();
        clear_n = 1'b0;
        #1;
        chk("div_rst_op", 32'(alu_op), 32'd0);
        chk("div_rst_rd_a", 32'(rf_rd_a), 32'd0);
        chk("div_rst_rd_b", 32'(rf_rd_b), 32'd0);
        chk("div_rst_wr_addr", 32'(rf_wr_addr), 32'd0);
        chk("div_rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("div_rst_done", 32'(done), 32'd0);
        chk("div_rst_illegal", 32'(illegal), 32'd0);
        neg();
        neg();
        clear_n = 1'b1;
        #1;
        chk("div_rst_ready", 32'(instr_ready), 32'd1);
        exp_q.push_back({4'd1, 4'd3});
        send(16'h3123);
        for (int k = 0; k < 4; k++) neg();
        chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

        // reset landing in WRITE suppresses the write
        send(16'h3555);
        neg();
        neg();
        @(posedge clock);
        #1;
        clear_n = 1'b0;
        neg();
        chk("write_rst_no_wr", 32'(rf_wr_en), 32'd0);
        chk("write_rst_done", 32'(done), 32'd0);
        clear_n = 1'b1;
        neg();
        chk("write_rst_ready", 32'(instr_ready), 32'd1);

`ifdef ALU_SEQ_FLAGS_EN
        exp_q.push_back({4'd1, 4'd4});
        alu_result = 8'h00;
        send(16'h4123);
        for (int k = 0; k < 4; k++) neg();
        chk("flag_z_zero", 32'(flag_z), 32'd1);
        chk("flag_n_zero", 32'(flag_n), 32'd0);
        exp_q.push_back({4'd1, 4'd4});
        alu_result = 8'h80;
        send(16'h4123);
        for (int k = 0; k < 4; k++) neg();
        chk("flag_z_neg", 32'(flag_z), 32'd0);
        chk("flag_n_neg", 32'(flag_n), 32'd1);
        alu_result = 8'h00;
        send(16'hD000);
        neg();
        neg();
        chk("flag_z_nop_hold", 32'(flag_z), 32'd0);
        chk("flag_n_nop_hold", 32'(flag_n), 32'd1);
`endif

        chk("final_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
